// File: rtl/spi_wb_bridge.sv
// SPI mode-0 target that decodes host frames into Wishbone initiator cycles; SCLK is oversampled in clk.
// Define SPI_WB_BURST_EN for multi-word frames with auto-incrementing word address.
module spi_wb_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_cs_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [6:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    RBUS = 3'd2,
    DATA = 3'd3,
    WBUS = 3'd4,
    DONE = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   cs_d;
  logic                   sclk_d;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_fall;

  state_t      state,   state_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [31:0] shreg,   shreg_n;
  logic [6:0]  addr,    addr_n;
  logic        wr_cmd,  wr_cmd_n;
  logic        miso,    miso_n;
  logic        cyc,     cyc_n;
  logic        we,      we_n;
  logic [6:0]  adr,     adr_n;
  logic [31:0] dat,     dat_n;

  // Synchronizers reset to 0 so a frame already in flight at reset is never seen as a CS fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = cs_d & ~cs_s;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= 5'd0;
      shreg   <= 32'd0;
      addr    <= 7'd0;
      wr_cmd  <= 1'b0;
      miso    <= 1'b0;
      cyc     <= 1'b0;
      we      <= 1'b0;
      adr     <= 7'd0;
      dat     <= 32'd0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      addr    <= addr_n;
      wr_cmd  <= wr_cmd_n;
      miso    <= miso_n;
      cyc     <= cyc_n;
      we      <= we_n;
      adr     <= adr_n;
      dat     <= dat_n;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    addr_n    = addr;
    wr_cmd_n  = wr_cmd;
    miso_n    = miso;
    cyc_n     = cyc;
    we_n      = we;
    adr_n     = adr;
    dat_n     = dat;
    case (state)
      IDLE: begin
        miso_n = 1'b0;
        if (cs_fall) begin
          state_n   = CMD;
          bit_cnt_n = 5'd0;
          shreg_n   = 32'd0;
        end else begin
          state_n = IDLE;
        end
      end
      CMD: begin
        if (cs_s) begin
          state_n = IDLE;
        end else if (sclk_rise) begin
          shreg_n   = {shreg[30:0], mosi_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt == 5'd7) begin
            // shreg[6] holds command bit 7 once seven bits have been shifted in
            wr_cmd_n  = shreg[6];
            addr_n    = {shreg[5:0], mosi_s};
            bit_cnt_n = 5'd0;
            shreg_n   = 32'd0;
            state_n   = shreg[6] ? DATA : RBUS;
          end else begin
            state_n = CMD;
          end
        end else begin
          state_n = CMD;
        end
      end
      RBUS, WBUS: begin
        if (!cyc) begin
          cyc_n = 1'b1;
          we_n  = (state == WBUS);
          adr_n = addr;
          dat_n = (state == WBUS) ? shreg : dat;
        end else if (wb_ack_i) begin
          cyc_n = 1'b0;
          we_n  = 1'b0;
          if (cs_s) begin
            state_n = IDLE;
            miso_n  = 1'b0;
          end else if (state == RBUS) begin
            // first read bit goes straight onto MISO ahead of the next rising edge
            state_n = DATA;
            shreg_n = wb_dat_i;
            miso_n  = wb_dat_i[31];
          end else begin
`ifdef SPI_WB_BURST_EN
            state_n = DATA;
            addr_n  = addr + 7'd1;
            shreg_n = 32'd0;
`else
            state_n = DONE;
`endif
          end
        end else begin
          cyc_n = 1'b1;
        end
      end
      DATA: begin
        if (cs_s) begin
          state_n = IDLE;
          miso_n  = 1'b0;
        end else if (sclk_rise) begin
          shreg_n   = {shreg[30:0], mosi_s};
          bit_cnt_n = bit_cnt + 5'd1;
          if (bit_cnt != 5'd31) begin
            state_n = DATA;
          end else if (wr_cmd) begin
            state_n = WBUS;
          end else begin
`ifdef SPI_WB_BURST_EN
            addr_n  = addr + 7'd1;
            state_n = RBUS;
`else
            miso_n  = 1'b0;
            state_n = DONE;
`endif
          end
        end else if (sclk_fall) begin
          miso_n = shreg[31];
        end else begin
          state_n = DATA;
        end
      end
      DONE: begin
        miso_n  = 1'b0;
        state_n = cs_s ? IDLE : DONE;
      end
      default: begin
        miso_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  assign spi_miso = miso;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = we;
  assign wb_adr_o = adr;
  assign wb_dat_o = dat;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Scoreboard bench for spi_wb_bridge: a frame-level reference model queues expected bus cycles and
// MISO words; one negedge monitor compares everything the DUT presents.
module tb_spi_wb_bridge;

`ifdef SPI_WB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int HALF = 8;

  typedef struct {
    logic        we;
    logic [6:0]  adr;
    logic [31:0] dat;
    int          len;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [6:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  logic [31:0] mem     [0:127];
  logic [31:0] ref_mem [0:127];
  logic [31:0] wr_words [0:3];
  logic        init_mem = 1'b0;
  int          ack_delay = 0;
  int          stb_cnt = 0;

  bus_t        exp_bus [$];
  logic [31:0] exp_rx  [$];
  logic [31:0] rx_q    [$];
  int          chk_q   [$];

  int          errors = 0;
  int          checks = 0;

  spi_wb_bridge #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  always #5 clk = ~clk;

  // Register-file responder with programmable ack delay (0 = combinational ack).
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 128; i++) mem[i] <= ref_mem[i];
    end else if (wb_cyc_o && wb_stb_o && wb_we_o && wb_ack_i) begin
      mem[wb_adr_o] <= wb_dat_o;
    end
    if (wb_cyc_o && !wb_ack_i) stb_cnt <= stb_cnt + 1;
    else stb_cnt <= 0;
  end
  assign wb_ack_i = wb_cyc_o && wb_stb_o && (stb_cnt >= ack_delay);
  assign wb_dat_i = mem[wb_adr_o];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Single monitor: bus cycles, received MISO words and stimulus-requested checks.
  int          stb_len = 0;
  logic        cur_we;
  logic [6:0]  cur_adr;
  logic [31:0] cur_dat;
  always @(negedge clk) begin
    bus_t        e;
    logic [31:0] got;
    int          req;
    if (wb_cyc_o || wb_stb_o) begin
      chk("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
      if (stb_len == 0) begin
        cur_we  = wb_we_o;
        cur_adr = wb_adr_o;
        cur_dat = wb_dat_o;
      end else begin
        chk("adr_stable", 32'(wb_adr_o), 32'(cur_adr));
        chk("dat_stable", wb_dat_o, cur_dat);
        chk("we_stable", 32'(wb_we_o), 32'(cur_we));
      end
      stb_len++;
      if (wb_ack_i) begin
        chk("bus_cycle_expected", 32'(exp_bus.size() > 0), 32'd1);
        if (exp_bus.size() > 0) begin
          e = exp_bus.pop_front();
          chk("bus_we", 32'(cur_we), 32'(e.we));
          chk("bus_adr", 32'(cur_adr), 32'(e.adr));
          if (e.we) chk("bus_dat", cur_dat, e.dat);
          chk("stb_cycles", 32'(stb_len), 32'(e.len));
        end
        stb_len = 0;
      end
    end
    if (rx_q.size() > 0) begin
      got = rx_q.pop_front();
      chk("rx_expected", 32'(exp_rx.size() > 0), 32'd1);
      if (exp_rx.size() > 0) chk("miso_word", got, exp_rx.pop_front());
    end
    if (chk_q.size() > 0) begin
      req = chk_q.pop_front();
      case (req)
        1: begin
          chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
          chk("rst_stb", 32'(wb_stb_o), 32'd0);
          chk("rst_we", 32'(wb_we_o), 32'd0);
          chk("rst_adr", 32'(wb_adr_o), 32'd0);
          chk("rst_dat", wb_dat_o, 32'd0);
          chk("rst_miso", 32'(spi_miso), 32'd0);
        end
        2: begin
          chk("bus_left", 32'(exp_bus.size()), 32'd0);
          chk("rx_left", 32'(exp_rx.size()), 32'd0);
        end
        default: ;
      endcase
    end
  end

  // Reference model: expected bus cycles and MISO words for a frame of nbits bits.
  task automatic model_frame(input logic [7:0] cmd, input int nbits);
    int         words;
    int         nbus;
    logic [6:0] a;
    bus_t       e;
    a     = cmd[6:0];
    words = (nbits >= 8) ? (nbits - 8) / 32 : 0;
    if (cmd[7]) begin
      nbus = BURST ? words : ((words > 0) ? 1 : 0);
      for (int i = 0; i < nbus; i++) begin
        e = '{we: 1'b1, adr: a, dat: wr_words[i], len: ack_delay + 1};
        exp_bus.push_back(e);
        ref_mem[a] = wr_words[i];
        a = a + 7'd1;
      end
    end else if (nbits >= 8) begin
      nbus = BURST ? words + 1 : 1;
      for (int i = 0; i < nbus; i++) begin
        e = '{we: 1'b0, adr: a, dat: 32'd0, len: ack_delay + 1};
        exp_bus.push_back(e);
        if (i < words) exp_rx.push_back(ref_mem[a]);
        a = a + 7'd1;
      end
      for (int i = nbus; i < words; i++) exp_rx.push_back(32'd0);
    end
  endtask

  // SPI host: sends cmd then wr_words MSB first; optional 1-cycle rst after bit rst_at.
  task automatic spi_frame(input logic [7:0] cmd, input int nbits, input int rst_at);
    logic [31:0] tx;
    logic [31:0] rx;
    logic        sampled;
    rx = 32'd0;
    tx = 32'd0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k == 0) tx = {cmd, 24'd0};
      else if (k >= 8 && (k - 8) % 32 == 0) tx = wr_words[(k - 8) / 32];
      spi_mosi = tx[31];
      tx = tx << 1;
      repeat (HALF) @(negedge clk);
      sampled  = spi_miso;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
      if (k >= 8) begin
        rx = {rx[30:0], sampled};
        if ((k - 8) % 32 == 31 && !cmd[7]) rx_q.push_back(rx);
      end
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_q.push_back(1);
      end
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic run(input logic [7:0] cmd, input int nbits);
    model_frame(cmd, nbits);
    spi_frame(cmd, nbits, -1);
  endtask

  task automatic load_mem();
    @(negedge clk);
    init_mem = 1'b1;
    @(negedge clk);
    init_mem = 1'b0;
  endtask

  initial begin
    logic [7:0] cmd;
    int         nw;
    rst      = 1'b1;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    for (int i = 0; i < 128; i++) ref_mem[i] = $urandom;
    for (int i = 0; i < 4; i++) wr_words[i] = 32'd0;
    repeat (3) @(negedge clk);
    chk_q.push_back(1);
    load_mem();
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // single write
    ack_delay = 0;
    wr_words[0] = 32'hDEADBEEF;
    run(8'h85, 40);

    // single read
    ref_mem[3] = 32'h12345678;
    load_mem();
    run(8'h03, 40);

    // aborted write then a clean one
    wr_words[0] = 32'hCAFEF00D;
    run(8'h85, 20);
    wr_words[0] = 32'h00000001;
    run(8'h81, 40);

    // delayed ack holds the strobe for four cycles
    ack_delay = 3;
    wr_words[0] = 32'hA5A55A5A;
    run(8'h9C, 40);
    ack_delay = 0;

    // reset mid-DATA of a read, then a normal frame
    model_frame(8'h0A, 8);
    spi_frame(8'h0A, 30, 20);
    run(8'h05, 40);

    // burst across the address wrap
    wr_words[0] = 32'h11111111;
    wr_words[1] = 32'h22222222;
    run(8'hFF, 72);
    run(8'h7F, 72);

    // randomized frames
    for (int n = 0; n < 10; n++) begin
      nw  = $urandom_range(1, 3);
      cmd = 8'($urandom);
      for (int i = 0; i < 4; i++) wr_words[i] = $urandom;
      ack_delay = cmd[7] ? $urandom_range(0, 3) : $urandom_range(0, 1);
      run(cmd, 8 + 32 * nw);
    end

    for (int i = 0; i < 500 && (exp_bus.size() > 0 || exp_rx.size() > 0); i++) @(negedge clk);
    chk_q.push_back(2);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
